// File: rtl/lda_cmdq_pkg.sv
// -----------------------------------------------------------------------------
// lda_cmdq_pkg
// Shared definitions for the line-drawing accelerator command-queue controller:
//   - lda_addr_t   : Avalon word addresses of the register map
//   - STAT_*       : bit positions inside the STATUS register
//   - MODE_*       : bit positions inside the MODE register
//   - IRQ_CLR_*    : bit positions inside the IRQ_CLR register
//   - lda_cmd_t    : line command layout {sp_x, sp_y, ep_x, ep_y, col} at the
//                    default coordinate/colour widths
//   - lda_state_t  : dispatch FSM states
// -----------------------------------------------------------------------------
package lda_cmdq_pkg;

   // Default geometry of the accelerator; the top level uses these as the
   // defaults of its width parameters.
   localparam int LDA_ADDR_W = 3;
   localparam int LDA_XW     = 9;
   localparam int LDA_YW     = 8;
   localparam int LDA_COLW   = 3;

   // Point registers carry y in the upper half-word.
   localparam int COORD_Y_LSB = 16;

   typedef enum logic [LDA_ADDR_W-1:0] {
      ADDR_MODE    = 3'd0,
      ADDR_STATUS  = 3'd1,
      ADDR_GO      = 3'd2,
      ADDR_START_P = 3'd3,
      ADDR_END_P   = 3'd4,
      ADDR_COLOR   = 3'd5,
      ADDR_LEVEL   = 3'd6,
      ADDR_IRQ_CLR = 3'd7
   } lda_addr_t;

   localparam int STAT_BUSY     = 0;
   localparam int STAT_FULL     = 1;
   localparam int STAT_EMPTY    = 2;
   localparam int STAT_OVERFLOW = 3;
   localparam int STAT_IRQ_PEND = 4;

   localparam int MODE_POLL   = 0;
   localparam int MODE_IRQ_EN = 1;

   localparam int IRQ_CLR_PEND = 0;
   localparam int IRQ_CLR_OVF  = 1;

   // Field order of a queued command, most significant field first. The top
   // level rebuilds the same layout from its own width parameters.
   typedef struct packed {
      logic [LDA_XW-1:0]   sp_x;
      logic [LDA_YW-1:0]   sp_y;
      logic [LDA_XW-1:0]   ep_x;
      logic [LDA_YW-1:0]   ep_y;
      logic [LDA_COLW-1:0] col;
   } lda_cmd_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2
   } lda_state_t;

endpackage

// File: rtl/lda_cmdq_control_if.sv
// -----------------------------------------------------------------------------
// lda_cmdq_control_if
// Avalon-MM register port of the command-queue controller.
//   i_address     : register word address
//   i_read        : read strobe
//   i_write       : write strobe
//   i_writedata   : write data
//   o_readdata    : read data, combinational, valid in the read cycle
//   o_waitrequest : stall, only raised by a GO write on a full queue
// Signal names are seen from the controller (slave) side.
// -----------------------------------------------------------------------------
interface lda_cmdq_control_if;
   import lda_cmdq_pkg::*;

   logic [LDA_ADDR_W-1:0] i_address;
   logic                  i_read;
   logic                  i_write;
   logic [31:0]           i_writedata;
   logic [31:0]           o_readdata;
   logic                  o_waitrequest;

   modport slave (
      input  i_address,
      input  i_read,
      input  i_write,
      input  i_writedata,
      output o_readdata,
      output o_waitrequest
   );

   modport master (
      output i_address,
      output i_read,
      output i_write,
      output i_writedata,
      input  o_readdata,
      input  o_waitrequest
   );

endinterface

// File: rtl/lda_cmd_fifo.sv
// -----------------------------------------------------------------------------
// lda_cmd_fifo
// DEPTH-entry FIFO (DEPTH a power of two) with a registered head output.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   push / din       : write din at the clock edge (ignored when full)
//   pop              : advance to the next entry (ignored when empty)
//   dout             : current head entry, held in a register
//   full / empty     : occupancy flags
//   count            : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module lda_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_next;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   // Pointers are exactly log2(DEPTH) wide, so the increment wraps for free.
   assign rd_next = rd_ptr + 1'b1;

   // Storage array; no reset needed because count guards every read.
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers, occupancy and the registered head. The head is refreshed from
   // din when the new entry becomes the oldest one (push into an empty queue,
   // or push while the last entry is being popped), otherwise from the entry
   // behind the one being popped.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_next;
         end

         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         if (do_pop) begin
            if (count > CNT_W'(1)) begin
               dout <= mem[rd_next];
            end else if (do_push) begin
               dout <= din;
            end
         end else if (do_push && empty) begin
            dout <= din;
         end
      end
   end

endmodule

// File: rtl/lda_cmdq_control.sv
// -----------------------------------------------------------------------------
// lda_cmdq_control
// Avalon-MM slave controller for the line-drawing accelerator. Software stages
// start point, end point and colour, then writes GO to queue the command; the
// dispatch FSM launches the engine whenever the queue holds a command.
//   i_clk, i_reset_n        : clock, asynchronous active-low reset
//   bus (slave modport)     : Avalon register port
//   o_start                 : one-cycle launch pulse to the draw engine
//   o_sp_x/o_sp_y           : start point of the current command
//   o_ep_x/o_ep_y           : end point of the current command
//   o_col                   : colour of the current command
//   i_done                  : engine completion pulse
//   o_irq                   : level interrupt (irq_pend & irq_en, registered)
// Register map: 0 MODE, 1 STATUS, 2 GO, 3 START_P, 4 END_P, 5 COLOR,
// 6 LEVEL, 7 IRQ_CLR.
// -----------------------------------------------------------------------------
module lda_cmdq_control
   import lda_cmdq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XW    = LDA_XW,
   parameter int YW    = LDA_YW,
   parameter int COLW  = LDA_COLW
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   lda_cmdq_control_if.slave  bus,
   output logic               o_start,
   output logic [XW-1:0]      o_sp_x,
   output logic [YW-1:0]      o_sp_y,
   output logic [XW-1:0]      o_ep_x,
   output logic [YW-1:0]      o_ep_y,
   output logic [COLW-1:0]    o_col,
   input  logic               i_done,
   output logic               o_irq
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   // Same field order as lda_cmd_t, sized by this instance's parameters.
   typedef struct packed {
      logic [XW-1:0]   sp_x;
      logic [YW-1:0]   sp_y;
      logic [XW-1:0]   ep_x;
      logic [YW-1:0]   ep_y;
      logic [COLW-1:0] col;
   } cmd_t;

   lda_addr_t        addr;
   lda_state_t       state;
   lda_state_t       state_d;

   cmd_t             stage;
   cmd_t             cmd_q;
   cmd_t             fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   logic             mode_poll;
   logic             irq_en;
   logic             irq_en_d;
   logic             overflow;
   logic             overflow_d;
   logic             irq_pend;
   logic             irq_pend_d;

   logic             wr_mode;
   logic             wr_go;
   logic             wr_start_p;
   logic             wr_end_p;
   logic             wr_color;
   logic             wr_irq_clr;

   logic             push;
   logic             pop;
   logic             drained;
   logic             busy;
   logic [31:0]      rdata;
   logic             unused_wdata;

   assign addr         = lda_addr_t'(bus.i_address);
   assign unused_wdata = ^bus.i_writedata;

   // Write strobe decode. STATUS and LEVEL are read-only, so writes to them
   // fall into the default and are dropped.
   always_comb begin
      wr_mode    = 1'b0;
      wr_go      = 1'b0;
      wr_start_p = 1'b0;
      wr_end_p   = 1'b0;
      wr_color   = 1'b0;
      wr_irq_clr = 1'b0;
      if (bus.i_write) begin
         case (addr)
            ADDR_MODE:    wr_mode    = 1'b1;
            ADDR_GO:      wr_go      = 1'b1;
            ADDR_START_P: wr_start_p = 1'b1;
            ADDR_END_P:   wr_end_p   = 1'b1;
            ADDR_COLOR:   wr_color   = 1'b1;
            ADDR_IRQ_CLR: wr_irq_clr = 1'b1;
            default:      ;
         endcase
      end
   end

   // A GO only pushes when the queue was not full at the start of the cycle;
   // a pop in the same cycle does not help until the next one. On a full
   // queue, stall mode holds the master and poll mode drops the command.
   assign push              = wr_go & ~fifo_full;
   assign bus.o_waitrequest = wr_go & fifo_full & ~mode_poll;

   // MODE register and command staging registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         mode_poll <= 1'b0;
         irq_en    <= 1'b0;
         stage     <= '0;
      end else begin
         if (wr_mode) begin
            mode_poll <= bus.i_writedata[MODE_POLL];
            irq_en    <= bus.i_writedata[MODE_IRQ_EN];
         end
         if (wr_start_p) begin
            stage.sp_x <= bus.i_writedata[XW-1:0];
            stage.sp_y <= bus.i_writedata[COORD_Y_LSB +: YW];
         end
         if (wr_end_p) begin
            stage.ep_x <= bus.i_writedata[XW-1:0];
            stage.ep_y <= bus.i_writedata[COORD_Y_LSB +: YW];
         end
         if (wr_color) begin
            stage.col <= bus.i_writedata[COLW-1:0];
         end
      end
   end

   lda_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(cmd_t))
   ) u_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .push      (push),
      .pop       (pop),
      .din       (stage),
      .dout      (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Dispatch FSM state register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Dispatch FSM next state. The pop is taken from the registered empty
   // flag, so a command pushed into an empty queue launches one cycle later.
   // The drain interrupt fires when the engine finishes with nothing left
   // queued and nothing arriving in the same cycle.
   always_comb begin
      state_d = state;
      pop     = 1'b0;
      drained = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (i_done) begin
               state_d = S_IDLE;
               drained = fifo_empty & ~push;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_start = (state == S_START);
   assign busy    = (state != S_IDLE) | ~fifo_empty;

   // Current command registers, held until the next pop.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cmd_q <= '0;
      end else if (pop) begin
         cmd_q <= fifo_dout;
      end
   end

   assign o_sp_x = cmd_q.sp_x;
   assign o_sp_y = cmd_q.sp_y;
   assign o_ep_x = cmd_q.ep_x;
   assign o_ep_y = cmd_q.ep_y;
   assign o_col  = cmd_q.col;

   // Sticky flags: a set event in the same cycle as a software clear wins.
   always_comb begin
      irq_pend_d = irq_pend;
      overflow_d = overflow;
      irq_en_d   = irq_en;
      if (wr_irq_clr && bus.i_writedata[IRQ_CLR_PEND]) begin
         irq_pend_d = 1'b0;
      end
      if (wr_irq_clr && bus.i_writedata[IRQ_CLR_OVF]) begin
         overflow_d = 1'b0;
      end
      if (drained) begin
         irq_pend_d = 1'b1;
      end
      if (wr_go && fifo_full && mode_poll) begin
         overflow_d = 1'b1;
      end
      if (wr_mode) begin
         irq_en_d = bus.i_writedata[MODE_IRQ_EN];
      end
   end

   // o_irq is built from the next-state values so that the flop always equals
   // irq_pend & irq_en and follows a clear in the following cycle.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         irq_pend <= 1'b0;
         overflow <= 1'b0;
         o_irq    <= 1'b0;
      end else begin
         irq_pend <= irq_pend_d;
         overflow <= overflow_d;
         o_irq    <= irq_pend_d & irq_en_d;
      end
   end

   // Read mux. Unused bits, write-only registers and idle cycles return 0.
   always_comb begin
      rdata = '0;
      if (bus.i_read) begin
         case (addr)
            ADDR_MODE: begin
               rdata[MODE_POLL]   = mode_poll;
               rdata[MODE_IRQ_EN] = irq_en;
            end
            ADDR_STATUS: begin
               rdata[STAT_BUSY]     = busy;
               rdata[STAT_FULL]     = fifo_full;
               rdata[STAT_EMPTY]    = fifo_empty;
               rdata[STAT_OVERFLOW] = overflow;
               rdata[STAT_IRQ_PEND] = irq_pend;
            end
            ADDR_START_P: begin
               rdata[XW-1:0]             = stage.sp_x;
               rdata[COORD_Y_LSB +: YW]  = stage.sp_y;
            end
            ADDR_END_P: begin
               rdata[XW-1:0]             = stage.ep_x;
               rdata[COORD_Y_LSB +: YW]  = stage.ep_y;
            end
            ADDR_COLOR: begin
               rdata[COLW-1:0] = stage.col;
            end
            ADDR_LEVEL: begin
               rdata[CNT_W-1:0] = fifo_count;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_readdata = rdata;

endmodule

// File: tb/tb_lda_cmdq_control.sv
// -----------------------------------------------------------------------------
// tb_lda_cmdq_control
// Directed bench for lda_cmdq_control: register reset values, single command
// launch, stall and poll backpressure on a full queue, in-order dispatch with
// the drain interrupt, and reset in the middle of a draw.
// -----------------------------------------------------------------------------
module tb_lda_cmdq_control;
   import lda_cmdq_pkg::*;

   localparam int DEPTH = 4;
   localparam int XW    = 9;
   localparam int YW    = 8;
   localparam int COLW  = 3;

   logic            i_clk = 1'b0;
   logic            i_reset_n;
   logic            o_start;
   logic [XW-1:0]   o_sp_x;
   logic [YW-1:0]   o_sp_y;
   logic [XW-1:0]   o_ep_x;
   logic [YW-1:0]   o_ep_y;
   logic [COLW-1:0] o_col;
   logic            i_done;
   logic            o_irq;

   int checks       = 0;
   int failures     = 0;
   int stall_cycles = 0;

   lda_cmdq_control_if bus ();

   lda_cmdq_control #(
      .DEPTH (DEPTH),
      .XW    (XW),
      .YW    (YW),
      .COLW  (COLW)
   ) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .bus       (bus),
      .o_start   (o_start),
      .o_sp_x    (o_sp_x),
      .o_sp_y    (o_sp_y),
      .o_ep_x    (o_ep_x),
      .o_ep_y    (o_ep_y),
      .o_col     (o_col),
      .i_done    (i_done),
      .o_irq     (o_irq)
   );

   always #5 i_clk = ~i_clk;

   // Every comparison of the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Avalon write, honouring waitrequest with a bounded wait.
   task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
      int waited;
      waited = 0;
      bus.i_address   = addr;
      bus.i_writedata = data;
      bus.i_write     = 1'b1;
      forever begin
         @(negedge i_clk);
         if (!bus.o_waitrequest) break;
         waited++;
         stall_cycles++;
         if (waited > 60) begin
            checkOutput("write_timeout", 32'(waited), 32'd0);
            break;
         end
      end
      @(posedge i_clk);
      #1;
      bus.i_write = 1'b0;
   endtask

   task automatic readRegister(input logic [2:0] addr, output logic [31:0] data);
      bus.i_address = addr;
      bus.i_read    = 1'b1;
      @(negedge i_clk);
      data = bus.o_readdata;
      @(posedge i_clk);
      #1;
      bus.i_read = 1'b0;
   endtask

   task automatic expectReg(input string tag, input logic [2:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      readRegister(addr, d);
      checkOutput(tag, d, exp);
   endtask

   task automatic pulseDone();
      i_done = 1'b1;
      tick();
      i_done = 1'b0;
   endtask

   task automatic doReset();
      i_reset_n       = 1'b0;
      bus.i_read      = 1'b0;
      bus.i_write     = 1'b0;
      bus.i_address   = '0;
      bus.i_writedata = '0;
      i_done          = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
      tick();
   endtask

   // Runaway guard.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0] seen_cols [3];
      int         starts;
      logic       seen;

      // ---------------- reset values ----------------
      i_reset_n       = 1'b0;
      bus.i_read      = 1'b0;
      bus.i_write     = 1'b0;
      bus.i_address   = '0;
      bus.i_writedata = '0;
      i_done          = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      checkOutput("rst_start", o_start, 0);
      checkOutput("rst_irq", o_irq, 0);
      checkOutput("rst_wait", bus.o_waitrequest, 0);
      checkOutput("rst_col", o_col, 0);
      i_reset_n = 1'b1;
      tick();
      checkOutput("rdata_idle", bus.o_readdata, 0);
      expectReg("rst_mode", ADDR_MODE, 32'h0);
      expectReg("rst_status", ADDR_STATUS, 32'h04);
      expectReg("rst_level", ADDR_LEVEL, 32'h0);
      expectReg("rst_start_p", ADDR_START_P, 32'h0);

      // ---------------- register access and single command ----------------
      applyStimulus(ADDR_START_P, 32'hFFFF_FFFF);
      expectReg("start_p_mask", ADDR_START_P, 32'h00FF_01FF);
      applyStimulus(ADDR_STATUS, 32'hFFFF_FFFF);
      expectReg("status_ro", ADDR_STATUS, 32'h04);
      applyStimulus(ADDR_START_P, {16'd20, 16'd10});
      applyStimulus(ADDR_END_P, {16'd50, 16'd100});
      applyStimulus(ADDR_COLOR, 32'd5);
      expectReg("end_p_rb", ADDR_END_P, 32'h0032_0064);
      expectReg("color_rb", ADDR_COLOR, 32'h5);
      expectReg("go_read_zero", ADDR_GO, 32'h0);
      applyStimulus(ADDR_GO, 32'hDEAD_BEEF);
      checkOutput("go_start_early", o_start, 0);
      tick();
      checkOutput("go_start", o_start, 1);
      checkOutput("go_sp_x", o_sp_x, 10);
      checkOutput("go_sp_y", o_sp_y, 20);
      checkOutput("go_ep_x", o_ep_x, 100);
      checkOutput("go_ep_y", o_ep_y, 50);
      checkOutput("go_col", o_col, 5);
      tick();
      checkOutput("start_one_cycle", o_start, 0);
      expectReg("status_busy", ADDR_STATUS, 32'h05);
      repeat (27) tick();
      pulseDone();
      expectReg("status_done", ADDR_STATUS, 32'h14);
      checkOutput("irq_masked", o_irq, 0);
      checkOutput("cmd_held", o_sp_x, 10);
      applyStimulus(ADDR_IRQ_CLR, 32'h1);
      expectReg("status_clr", ADDR_STATUS, 32'h04);

      // ---------------- stall mode backpressure ----------------
      doReset();
      stall_cycles = 0;
      repeat (5) applyStimulus(ADDR_GO, 32'h0);
      checkOutput("stall_none_yet", 32'(stall_cycles), 0);
      expectReg("stall_level4", ADDR_LEVEL, 32'd4);
      expectReg("stall_status_full", ADDR_STATUS, 32'h03);
      bus.i_address = ADDR_GO;
      bus.i_write   = 1'b1;
      #1;
      checkOutput("stall_wait0", bus.o_waitrequest, 1);
      tick();
      checkOutput("stall_wait1", bus.o_waitrequest, 1);
      tick();
      i_done = 1'b1;
      #1;
      checkOutput("stall_wait_done", bus.o_waitrequest, 1);
      tick();
      i_done = 1'b0;
      #1;
      checkOutput("stall_after_done", bus.o_waitrequest, 1);
      tick();
      checkOutput("stall_release", bus.o_waitrequest, 0);
      checkOutput("stall_next_start", o_start, 1);
      tick();
      bus.i_write = 1'b0;
      expectReg("stall_level_back", ADDR_LEVEL, 32'd4);
      stall_cycles = 0;
      applyStimulus(ADDR_COLOR, 32'd2);
      checkOutput("full_color_no_stall", 32'(stall_cycles), 0);

      // ---------------- poll mode overflow ----------------
      doReset();
      applyStimulus(ADDR_MODE, 32'h1);
      stall_cycles = 0;
      repeat (6) applyStimulus(ADDR_GO, 32'h0);
      checkOutput("poll_no_wait", 32'(stall_cycles), 0);
      expectReg("poll_level4", ADDR_LEVEL, 32'd4);
      expectReg("poll_status_ovf", ADDR_STATUS, 32'h0B);
      expectReg("poll_mode_rb", ADDR_MODE, 32'h1);
      applyStimulus(ADDR_IRQ_CLR, 32'h2);
      expectReg("poll_ovf_clr", ADDR_STATUS, 32'h03);

      // ---------------- in-order dispatch and drain interrupt ----------------
      doReset();
      applyStimulus(ADDR_MODE, 32'h2);
      fork
         begin
            for (int c = 1; c <= 3; c++) begin
               applyStimulus(ADDR_COLOR, 32'(c));
               applyStimulus(ADDR_GO, 32'h0);
            end
         end
         begin
            for (int k = 0; k < 3; k++) begin
               seen = 1'b0;
               for (int g = 0; g < 60 && !seen; g++) begin
                  @(negedge i_clk);
                  seen = o_start;
               end
               seen_cols[k] = o_col;
               checkOutput($sformatf("order_start%0d", k), seen, 1);
               checkOutput($sformatf("order_irq_low%0d", k), o_irq, 0);
               repeat (3) @(posedge i_clk);
               #1;
               i_done = 1'b1;
               @(posedge i_clk);
               #1;
               i_done = 1'b0;
            end
         end
      join
      checkOutput("order_col0", seen_cols[0], 1);
      checkOutput("order_col1", seen_cols[1], 2);
      checkOutput("order_col2", seen_cols[2], 3);
      checkOutput("irq_rise", o_irq, 1);
      expectReg("irq_status", ADDR_STATUS, 32'h14);
      applyStimulus(ADDR_IRQ_CLR, 32'h1);
      checkOutput("irq_fall", o_irq, 0);
      expectReg("irq_status_clr", ADDR_STATUS, 32'h04);

      // ---------------- reset in the middle of a draw ----------------
      doReset();
      applyStimulus(ADDR_START_P, {16'd8, 16'd7});
      applyStimulus(ADDR_END_P, {16'd9, 16'd11});
      applyStimulus(ADDR_COLOR, 32'd6);
      repeat (3) applyStimulus(ADDR_GO, 32'h0);
      expectReg("mid_level2", ADDR_LEVEL, 32'd2);
      checkOutput("mid_sp_x_loaded", o_sp_x, 7);
      i_reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_start", o_start, 0);
      checkOutput("mid_rst_sp_x", o_sp_x, 0);
      checkOutput("mid_rst_sp_y", o_sp_y, 0);
      checkOutput("mid_rst_ep_x", o_ep_x, 0);
      checkOutput("mid_rst_col", o_col, 0);
      checkOutput("mid_rst_irq", o_irq, 0);
      checkOutput("mid_rst_wait", bus.o_waitrequest, 0);
      tick();
      i_reset_n = 1'b1;
      tick();
      expectReg("mid_level0", ADDR_LEVEL, 32'd0);
      expectReg("mid_status", ADDR_STATUS, 32'h04);
      pulseDone();
      starts = 0;
      for (int g = 0; g < 10; g++) begin
         @(negedge i_clk);
         if (o_start) starts++;
      end
      tick();
      checkOutput("mid_no_start", 32'(starts), 0);
      expectReg("mid_status_after_done", ADDR_STATUS, 32'h04);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lda_cmdq_control.md
Name: lda_cmdq_control

Overview:
- Avalon-MM slave controller for the line-drawing accelerator with a parametrised command queue of DEPTH line commands.
- Software stages start point, end point and colour, then writes GO to push the command. The block launches the draw engine whenever the queue is non-empty.
- Replaces the single-shot control: supports queued issue, stall or poll backpressure on a full queue, occupancy readback, sticky overflow and a drain-complete interrupt.

Parameters:
- DEPTH, 4, command queue entries; power of 2, ≥2.
- XW, 9, x coordinate width.
- YW, 8, y coordinate width.
- COLW, 3, colour width.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_address  in  3  register word address.
- i_read  in  1  Avalon read.
- i_write  in  1  Avalon write.
- i_writedata  in  32  write data.
- o_readdata  out  32  read data, combinational, valid the same cycle.
- o_waitrequest  out  1  Avalon stall.
- o_start  out  1  one-cycle launch pulse to the engine.
- o_sp_x / o_sp_y  out  XW / YW  current command start point.
- o_ep_x / o_ep_y  out  XW / YW  current command end point.
- o_col  out  COLW  current command colour.
- i_done  in  1  engine completion pulse.
- o_irq  out  1  level interrupt.

Behaviour:
- Register map:
  - 0 MODE: bit0 = 1 poll, 0 stall; bit1 = irq_en.
  - 1 STATUS (read-only): bit0 busy, bit1 full, bit2 empty, bit3 overflow, bit4 irq_pend.
  - 2 GO: write pushes the staged command; data ignored.
  - 3 START_P and 4 END_P: x in [XW-1:0], y in [16+YW-1:16].
  - 5 COLOR: [COLW-1:0].
  - 6 LEVEL (read-only): queue count, 0..DEPTH.
  - 7 IRQ_CLR (write-only): bit0 clears irq_pend, bit1 clears overflow.
- Register access:
  - Unused bits read 0. Reads of write-only registers return 0. Writes to read-only registers are ignored.
  - o_readdata = 0 when i_read = 0.
- Reset values: every output 0; MODE = 0; staging registers 0; queue empty; overflow = 0; irq_pend = 0; FSM in S_IDLE. Reset mid-draw abandons the command with no o_start and discards queue contents.
- GO write, queue not full: push {sp, ep, col} at the clock edge; no waitrequest.
- GO write, queue full, stall mode:
  - o_waitrequest = 1 combinationally while full.
  - The push completes on the first cycle the queue is not full at the start of that cycle. A pop in the same cycle does not release the stall until the next cycle.
- GO write, queue full, poll mode: the command is dropped, overflow is set, and o_waitrequest stays 0.
- Only GO writes ever raise o_waitrequest.
- Dispatch FSM:
  - S_IDLE: if the queue is non-empty, pop the head into the output command registers and go to S_START. Push to an empty queue → pop on the following cycle (no fall-through).
  - S_START: o_start = 1 for exactly one cycle → S_RUN.
  - S_RUN: on i_done → S_IDLE. If the queue is empty in that cycle and no push occurs, set irq_pend.
  - i_done outside S_RUN is ignored.
- Output command registers hold their value until the next pop.
- Push and pop in the same cycle: count unchanged; data ordering is FIFO. Pointers wrap modulo DEPTH.
- busy = (state != S_IDLE) | !empty.
- o_irq = irq_pend & irq_en, registered. Setting irq_pend and clearing it via IRQ_CLR in the same cycle: set wins.
- MODE changes apply to GO writes from the next cycle. A stalled GO whose MODE flips to poll stays stalled until MODE is written again; this cannot happen on a single master.

Decomposition:
- lda_cmdq_pkg:
  - lda_addr_t enum (the 8 addresses).
  - Status bit index localparams.
  - Parametrised command struct lda_cmd_t {sp_x, sp_y, ep_x, ep_y, col}.
  - FSM state enum.
- Sub-module lda_cmd_fifo (DEPTH, generic width):
  - Ports: push, pop, din, dout, full, empty, count.
  - Synchronous read head; asynchronous active-low reset.
- Top level holds the Avalon decode, staging registers, FSM and interrupt logic.

Test Plan:
- Reset, then read all registers → STATUS = 0x04, LEVEL = 0, MODE = 0; o_start, o_irq and o_waitrequest all 0.
- Stage sp = (10,20), ep = (100,50), col = 5, write GO → o_start pulses 2 cycles later with the staged values on the command outputs; STATUS busy = 1. i_done 30 cycles later → STATUS = 0x14.
- Stall mode, engine held (no i_done), DEPTH = 4: 6 GO writes → first 5 accepted (1 in engine, 4 queued), LEVEL = 4, 6th holds o_waitrequest = 1 until i_done. After i_done, accepts 2 cycles later; LEVEL returns to 4.
- Poll mode, same stimulus → 6th GO dropped, o_waitrequest never 1, STATUS overflow = 1. IRQ_CLR write 0x2 → overflow = 0.
- irq_en = 1, queue 3 commands with colours 1, 2, 3 → o_start pulses in order with o_col 1, 2, 3; o_irq rises only after the third i_done. IRQ_CLR 0x1 → o_irq falls next cycle.
- Assert i_reset_n low during S_RUN with LEVEL = 2 → all outputs 0, queue empty. After release, i_done is ignored and no o_start occurs.
